gcd_engine: RTL and testbench

- Self-contained, parametrised GCD engine: subtractive datapath, its controller, and a start/busy/done handshake in one block.
- Successor to the fixed 8-bit x/y datapath. It adds:
  - generic operand width;
  - zero-operand handling with an error flag;
  - an iteration counter;
  - abort.
- Sits beside other arithmetic units, driven by a host FSM or bus wrapper.

---
 rtl/gcd_engine.sv | 64 ++++++
 tb/tb_gcd_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD (start/busy/done, abort, err on 0/0, iter_cnt = subtractions of last completed run)
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [WIDTH-1:0] iter_cnt
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [WIDTH-1:0] x_reg, y_reg, cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      x_reg    <= '0;
      y_reg    <= '0;
      cnt      <= '0;
      result   <= '0;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && (x_in == '0 || y_in == '0)) begin
          result   <= x_in | y_in;
          err      <= x_in == '0 && y_in == '0;
          iter_cnt <= '0;
          done     <= 1'b1;
        end else if (start) begin
          x_reg <= x_in;
          y_reg <= y_in;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (x_reg == y_reg) begin
        result   <= x_reg;
        err      <= 1'b0;
        iter_cnt <= cnt;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= IDLE;
      end else if (x_reg > y_reg) begin
        x_reg <= x_reg - y_reg;
        cnt   <= cnt + WIDTH'(1);
      end else begin
        y_reg <= y_reg - x_reg;
        cnt   <= cnt + WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: table, hand-written and random checks of gcd_engine at WIDTH=8 and WIDTH=16
module tb_gcd_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, abort8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic busy8, done8, err8;
  logic [7:0] res8, it8;
  logic start16 = 1'b0, abort16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;
  logic busy16, done16, err16;
  logic [15:0] res16, it16;
  logic wide = 1'b0;
  logic c_busy, c_done, c_err;
  logic [15:0] c_res, c_it;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .x_in(x8), .y_in(y8),
    .busy(busy8), .done(done8), .result(res8), .err(err8), .iter_cnt(it8)
  );
  gcd_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .abort(abort16), .x_in(x16), .y_in(y16),
    .busy(busy16), .done(done16), .result(res16), .err(err16), .iter_cnt(it16)
  );

  always_comb begin
    c_busy = wide ? busy16 : busy8;
    c_done = wide ? done16 : done8;
    c_err  = wide ? err16 : err8;
    c_res  = wide ? res16 : {8'd0, res8};
    c_it   = wide ? it16 : {8'd0, it8};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Euclid by division: the subtractive method performs sum(quotients)-1 steps
  function automatic void model(input longint unsigned a, input longint unsigned b,
                                output longint unsigned g, output longint unsigned n, output bit e);
    longint unsigned p, q, t;
    n = 0;
    e = (a == 0 && b == 0);
    if (a == 0 || b == 0) begin
      g = a | b;
      return;
    end
    p = a;
    q = b;
    while (q != 0) begin
      n += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    g = p;
    n = n - 1;
  endfunction

  task automatic apply(input bit w, input longint unsigned x, input longint unsigned y);
    wide = w;
    if (w) begin
      start16 = 1'b1; x16 = 16'(x); y16 = 16'(y);
    end else begin
      start8 = 1'b1; x8 = 8'(x); y8 = 8'(y);
    end
  endtask

  task automatic release_start;
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done8(input int limit);
    int k;
    k = 0;
    while (!done8 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done8) chk("done timeout", 0, 1);
  endtask

  task automatic run(input bit w, input longint unsigned x, input longint unsigned y, input string nm,
                     input longint unsigned er, input longint unsigned en, input bit ee);
    int k, bc, lat;
    lat = (x == 0 || y == 0) ? 1 : int'(en) + 2;
    k = 1;
    bc = 0;
    @(negedge clk);
    apply(w, x, y);
    @(negedge clk);
    release_start;
    while (!c_done && k < lat + 20) begin
      bc += int'(c_busy);
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s latency", nm), k, lat);
    chk($sformatf("%s result", nm), c_res, er);
    chk($sformatf("%s err", nm), c_err, ee);
    chk($sformatf("%s iter_cnt", nm), c_it, en);
    chk($sformatf("%s busy cycles", nm), bc, lat - 1);
    @(negedge clk);
    chk($sformatf("%s done pulse width", nm), c_done, 0);
  endtask

  typedef struct {
    longint unsigned x, y, r, n;
    bit e;
  } vec_t;
  vec_t tbl[11];

  initial begin
    longint unsigned x, y, g, n;
    bit e, seen;
    tbl[0]  = '{48, 18, 6, 4, 0};
    tbl[1]  = '{255, 1, 1, 254, 0};
    tbl[2]  = '{1, 255, 1, 254, 0};
    tbl[3]  = '{0, 35, 35, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1};
    tbl[5]  = '{128, 0, 128, 0, 0};
    tbl[6]  = '{9, 9, 9, 0, 0};
    tbl[7]  = '{12, 8, 4, 2, 0};
    tbl[8]  = '{200, 8, 8, 24, 0};
    tbl[9]  = '{255, 255, 255, 0, 0};
    tbl[10] = '{2, 3, 1, 2, 0};

    #1 rst = 1'b0;
    #1;
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset result", res8, 0);
    chk("reset err", err8, 0);
    chk("reset iter_cnt", it8, 0);
    chk("reset busy16", busy16, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      run(0, tbl[i].x, tbl[i].y, $sformatf("vec%0d(%0d,%0d)", i, tbl[i].x, tbl[i].y),
          tbl[i].r, tbl[i].n, tbl[i].e);

    // second start while busy must be ignored
    @(negedge clk);
    apply(0, 255, 1);
    @(negedge clk);
    release_start;
    repeat (3) @(negedge clk);
    apply(0, 4, 2);
    @(negedge clk);
    release_start;
    wait_done8(400);
    chk("busy-start result", res8, 1);
    chk("busy-start iter_cnt", it8, 254);
    @(negedge clk);
    chk("busy-start not queued", busy8, 0);

    // start in the same cycle as done is accepted
    @(negedge clk);
    apply(0, 12, 8);
    @(negedge clk);
    release_start;
    wait_done8(40);
    apply(0, 9, 9);
    @(negedge clk);
    release_start;
    chk("start-on-done accepted", busy8, 1);
    wait_done8(40);
    chk("start-on-done result", res8, 9);

    // abort on the third CALC cycle
    run(0, 48, 18, "pre-abort", 6, 4, 0);
    apply(0, 200, 8);
    @(negedge clk);
    release_start;
    @(negedge clk);
    @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    chk("abort busy", busy8, 0);
    seen = done8;
    repeat (30) begin
      @(negedge clk);
      seen |= done8;
    end
    chk("abort no done", seen, 0);
    chk("abort result held", res8, 6);
    chk("abort iter_cnt held", it8, 4);
    chk("abort err held", err8, 0);
    run(0, 9, 9, "post-abort", 9, 0, 0);

    // asynchronous reset mid-CALC
    apply(0, 200, 8);
    @(negedge clk);
    release_start;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", busy8, 0);
    chk("async rst done", done8, 0);
    chk("async rst result", res8, 0);
    chk("async rst iter_cnt", it8, 0);
    chk("async rst err", err8, 0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 12, 8, "post-reset", 4, 2, 0);

    // 8-bit random against the Euclid model
    repeat (40) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) x = 0;
      if ($urandom_range(0, 7) == 0) y = 0;
      model(x, y, g, n, e);
      run(0, x, y, $sformatf("rnd8(%0d,%0d)", x, y), g, n, e);
    end

    // 16-bit: boundary vector plus bounded-length randoms
    run(1, 65535, 4369, "w16(65535,4369)", 4369, 14, 0);
    run(1, 0, 0, "w16(0,0)", 0, 0, 1);
    repeat (10) begin
      do begin
        x = $urandom_range(1, 65535);
        y = $urandom_range(1, 65535);
        model(x, y, g, n, e);
      end while (n > 3000);
      run(1, x, y, $sformatf("rnd16(%0d,%0d)", x, y), g, n, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
